// File: rtl/uart_psram_cmd_host.sv
// uart_psram_cmd_host
// Turns host frames arriving as UART RX bytes into PSRAM read/write requests and
// returns a status byte (plus read data on a good read) over the UART TX byte link.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Once valid is raised the payload holds steady and valid stays high until
// that transfer. rx_valid has no ready and is a single-cycle strobe. rsp_valid is
// a single-cycle strobe that is honoured only in WAIT.
module uart_psram_cmd_host #(
  parameter int BYTE_TIMEOUT = 100_000,
  parameter int RSP_TIMEOUT  = 1_024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_rw,
  output logic [22:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  input  logic        rsp_error,
  output logic [3:0]  process,
  output logic        error,
  output logic        busy
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] STAT_OK  = 8'h4B;
  localparam logic [7:0] STAT_ERR = 8'h45;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int RT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RSP_TIMEOUT - 1);

  // State encodings double as the debug process code.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADDR  = 4'd1,
    S_DATA  = 4'd2,
    S_ISSUE = 4'd3,
    S_WAIT  = 4'd4,
    S_TX_ST = 4'd5,
    S_TX_HI = 4'd6,
    S_TX_LO = 4'd7
  } state_t;

  state_t          r_state;
  logic [1:0]      r_cnt;
  logic            r_is_read;
  logic [22:0]     r_addr;
  logic [15:0]     r_wdata;
  logic [15:0]     r_rdata;
  logic [BT_W-1:0] r_byte_tmr;
  logic [RT_W-1:0] r_rsp_tmr;
  logic            r_tx_valid;
  logic [7:0]      r_tx_data;
  logic            r_cmd_valid;
  logic [1:0]      r_cmd_rw;
  logic            r_error;
  logic            w_overrun;

  // A byte arriving while a request or reply is in flight cannot be buffered.
  assign w_overrun = rx_valid &&
                     (r_state inside {S_ISSUE, S_WAIT, S_TX_ST, S_TX_HI, S_TX_LO});

  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign cmd_valid = r_cmd_valid;
  assign cmd_rw    = r_cmd_rw;
  assign cmd_addr  = r_addr;
  assign cmd_wdata = r_wdata;
  assign process   = r_state;
  assign error     = r_error;
  assign busy      = (r_state != S_IDLE);

  // Main control FSM: frame parsing, request issue, response wait and TX sequencing.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_read   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_byte_tmr  <= '0;
      r_rsp_tmr   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_rw    <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_overrun) begin
        r_error <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              r_is_read  <= (rx_data == OP_READ);
              r_cnt      <= '0;
              r_addr     <= '0;
              r_wdata    <= '0;
              r_byte_tmr <= '0;
              r_state    <= S_ADDR;
            end else begin
              r_is_read  <= 1'b0;
              r_tx_data  <= STAT_ERR;
              r_tx_valid <= 1'b1;
              r_error    <= 1'b1;
              r_state    <= S_TX_ST;
            end
          end
        end

        // Bit 7 of the first address byte falls off the top of the 23-bit shifter.
        S_ADDR: begin
          if (rx_valid) begin
            r_addr     <= {r_addr[14:0], rx_data};
            r_byte_tmr <= '0;
            if (r_cnt == 2'd2) begin
              r_cnt <= '0;
              if (r_is_read) begin
                r_cmd_valid <= 1'b1;
                r_cmd_rw    <= RW_READ;
                r_state     <= S_ISSUE;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end else if (r_byte_tmr == BT_LAST) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_byte_tmr <= r_byte_tmr + 1'b1;
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            r_wdata    <= {r_wdata[7:0], rx_data};
            r_byte_tmr <= '0;
            if (r_cnt == 2'd1) begin
              r_cnt       <= '0;
              r_cmd_valid <= 1'b1;
              r_cmd_rw    <= RW_WRITE;
              r_state     <= S_ISSUE;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end else if (r_byte_tmr == BT_LAST) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_byte_tmr <= r_byte_tmr + 1'b1;
          end
        end

        // The controller may stall indefinitely here; the response timer starts at accept.
        S_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_cmd_rw    <= '0;
            r_rsp_tmr   <= '0;
            r_state     <= S_WAIT;
          end
        end

        // A response on the expiry cycle is still taken as a response.
        S_WAIT: begin
          if (rsp_valid) begin
            r_rdata    <= rsp_rdata;
            r_tx_data  <= rsp_error ? STAT_ERR : STAT_OK;
            r_tx_valid <= 1'b1;
            if (rsp_error) begin
              r_error <= 1'b1;
            end
            r_state <= S_TX_ST;
          end else if (r_rsp_tmr == RT_LAST) begin
            r_tx_data  <= STAT_ERR;
            r_tx_valid <= 1'b1;
            r_error    <= 1'b1;
            r_state    <= S_TX_ST;
          end else begin
            r_rsp_tmr <= r_rsp_tmr + 1'b1;
          end
        end

        S_TX_ST: begin
          if (tx_ready) begin
            if (r_is_read && r_tx_data == STAT_OK) begin
              r_tx_data <= r_rdata[15:8];
              r_state   <= S_TX_HI;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end

        S_TX_HI: begin
          if (tx_ready) begin
            r_tx_data <= r_rdata[7:0];
            r_state   <= S_TX_LO;
          end
        end

        S_TX_LO: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
